// File: rtl/core_l1d_resp_if.sv
// core_l1d_resp_if: L1D request/response bus between the pipeline and the data memory
interface core_l1d_resp_if;
  logic        l1d_req_val;
  logic        l1d_req_cop;
  logic [2:0]  l1d_req_size;
  logic [31:0] l1d_req_addr;
  logic [31:0] l1d_req_wdata;
  logic        l1d_req_ack;
  logic [31:0] l1d_resp_rdata;
  logic        l1d_resp_err;
  logic        l1d_busy;
  modport master (
    output l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
    input  l1d_req_ack, l1d_resp_rdata, l1d_resp_err, l1d_busy
  );
  modport slave (
    input  l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
    output l1d_req_ack, l1d_resp_rdata, l1d_resp_err, l1d_busy
  );
endinterface

// File: rtl/core_l1d_resp.sv
// core_l1d_resp: single-outstanding L1D responder backed by a word SRAM with fixed latency
module core_l1d_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  core_l1d_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic cop;
  logic [2:0] size;
  logic [AW+1:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] lane, rdata_c, rdata_h, wlane;
  logic [3:0] be;
  logic err, err_h, accept;
  assign accept = state == IDLE && bus.l1d_req_val;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= 4'(LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end
  always_comb begin
    state_nxt = state == IDLE ? (bus.l1d_req_val ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  always_comb begin
    bus.l1d_req_ack = state == RESP;
    bus.l1d_busy = state != IDLE;
    bus.l1d_resp_rdata = state == RESP ? rdata_c : rdata_h;
    bus.l1d_resp_err = state == RESP ? err : err_h;
  end
  // request fields are frozen at acceptance so later bus changes cannot leak in
  always_ff @(posedge clk) begin
    if (accept) begin
      cop <= bus.l1d_req_cop;
      size <= bus.l1d_req_size;
      addr <= bus.l1d_req_addr[AW+1:0];
      wdata <= bus.l1d_req_wdata;
    end
  end
  always_comb begin
    err = size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'd0);
    lane = mem[addr[AW+1:2]] >> {addr[1:0], 3'b000};
    rdata_c = err || cop ? '0 : size == 3'd0 ? {24'b0, lane[7:0]} :
              size == 3'd1 ? {16'b0, lane[15:0]} : lane;
    be = size == 3'd0 ? 4'b0001 << addr[1:0] : size == 3'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
    wlane = wdata << {addr[1:0], 3'b000};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_h <= '0;
      err_h <= 1'b0;
    end else if (state == RESP) begin
      rdata_h <= rdata_c;
      err_h <= err;
    end
  end
  // store commits with the ack edge; a reset on that edge drops it
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && cop && !err)
      for (int j = 0; j < 4; j++)
        if (be[j]) mem[addr[AW+1:2]][8*j +: 8] <= wlane[8*j +: 8];
  end
endmodule
